// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the memory-port arbiter slice.
package mem_arb_pkg;

  localparam int unsigned RD_LAT_DEFAULT = 1;
  localparam int unsigned ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER_A,
    ST_XFER_B,
    ST_ACK
  } state_e;

  // Index of the final byte of an access (n-1).
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      SZ_BYTE: r = 2'd0;
      SZ_HALF: r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lsb);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lsb[0];
      SZ_WORD: r = (lsb != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                              input logic uns);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{~uns & raw[7]}}, raw[7:0]};
      SZ_HALF: r = {{16{~uns & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant; the last-grant register favours the other port on contention.
module mem_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic en_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // 1 = A was granted last; resets to B so A wins the first contest.
  logic last_a_q;

  always_comb begin
    gnt_a_o = req_a_i & (~req_b_i | ~last_a_q);
    gnt_b_o = req_b_i & (~req_a_i | last_a_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_a_q <= 1'b0;
    end else if (en_i && (gnt_a_o || gnt_b_o)) begin
      last_a_q <= gnt_a_o;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide system_ram port between a CPU load/store port (A) and a debug byte-read port (B).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_unsigned,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [7:0]        ram_q
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic              own_a_q, own_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       a_rdata_q, a_rdata_d;
  logic [7:0]        b_rdata_q, b_rdata_d;
  logic [31:0]       merged;
  logic              gnt_a, gnt_b, arb_en;

  mem_rr_arbiter u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_a_i (a_req),
    .req_b_i (b_req),
    .en_i    (arb_en),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    size_d    = size_q;
    addr_d    = addr_q;
    we_d      = we_q;
    uns_d     = uns_q;
    err_d     = err_q;
    own_a_d   = own_a_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    ram_addr  = '0;
    ram_data  = '0;
    ram_wren  = 1'b0;
    ram_rden  = 1'b0;
    arb_en    = 1'b0;
    merged    = buf_q;
    merged[{cnt_q, 3'b000} +: 8] = ram_q;

    unique case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
        cnt_d  = '0;
        wait_d = '0;
        buf_d  = '0;
        // Request attributes are latched at grant so the transfer is immune to input churn.
        if (gnt_a) begin
          own_a_d = 1'b1;
          addr_d  = a_addr;
          size_d  = a_size;
          we_d    = a_we;
          uns_d   = a_unsigned;
          wdata_d = a_wdata;
          err_d   = bad_access(a_size, a_addr[1:0]);
          state_d = bad_access(a_size, a_addr[1:0]) ? ST_ACK : ST_XFER_A;
        end else if (gnt_b) begin
          own_a_d = 1'b0;
          addr_d  = b_addr;
          size_d  = SZ_BYTE;
          we_d    = 1'b0;
          uns_d   = 1'b1;
          wdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_XFER_B;
        end
      end

      ST_XFER_A, ST_XFER_B: begin
        ram_addr = addr_q + ADDR_W'(cnt_q);
        if (we_q) begin
          ram_wren = 1'b1;
          ram_data = wdata_q[{cnt_q, 3'b000} +: 8];
          if (cnt_q == last_byte(size_q)) state_d = ST_ACK;
          else cnt_d = cnt_q + 2'd1;
        end else if (wait_q == 2'd0) begin
          ram_rden = 1'b1;
          wait_d   = 2'd1;
        end else if (wait_q == LAT) begin
          // Final wait cycle: ram_q is valid, fold it in and publish on the last byte.
          wait_d = '0;
          buf_d  = merged;
          if (cnt_q == last_byte(size_q)) begin
            state_d = ST_ACK;
            if (own_a_q) a_rdata_d = extend_load(merged, size_q, uns_q);
            else b_rdata_d = merged[7:0];
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      size_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      own_a_q   <= 1'b0;
      wdata_q   <= '0;
      buf_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      err_q     <= err_d;
      own_a_q   <= own_a_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack   = (state_q == ST_ACK) & own_a_q;
  assign a_err   = a_ack & err_q;
  assign b_ack   = (state_q == ST_ACK) & ~own_a_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural byte RAM (RD_LAT = 1).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, a_unsigned = 1'b0;
  logic [1:0]    a_size = 2'b00;
  logic [AW-1:0] a_addr = '0;
  logic [31:0]   a_wdata = '0;
  logic          a_ack, a_err;
  logic [31:0]   a_rdata;
  logic          b_req = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic          b_ack;
  logic [7:0]    b_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_wren, ram_rden;
  logic [7:0]    ram_q = '0;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int nwr = 0, nrd = 0, nviol = 0;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        err;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [7:0] mem [0:65535];

  mem_port_arbiter #(.RD_LAT(1), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_size     (a_size),
    .a_unsigned (a_unsigned),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_err      (a_err),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_addr     (b_addr),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_rden   (ram_rden),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle registered read; contents seeded on the first edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      mem[16'h0000] <= 8'hA5;
      mem[16'h0010] <= 8'h78;
      mem[16'h0011] <= 8'h56;
      mem[16'h0012] <= 8'h34;
      mem[16'h0013] <= 8'h12;
      mem[16'h0020] <= 8'h00;
      mem[16'h0021] <= 8'h00;
      mem[16'h0050] <= 8'h00;
      mem[16'h0051] <= 8'h00;
      mem[16'h0052] <= 8'h00;
      mem[16'h0053] <= 8'h00;
    end else begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      if (ram_rden) ram_q <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_wren) nwr = nwr + 1;
    if (ram_rden) nrd = nrd + 1;
    if ((ram_wren && ram_rden) || (!ram_wren && ram_data != 8'h00)) nviol = nviol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
    a_we = we; a_size = size; a_unsigned = uns; a_addr = addr; a_wdata = wdata;
    a_req = 1'b1;
  endtask

  task automatic expect_a(input logic [31:0] d, input logic cd, input logic er, input int lat);
    exp_t e;
    e.data = d; e.chk_data = cd; e.err = er; e.at = cyc + lat;
    qa.push_back(e);
  endtask

  task automatic expect_b(input logic [31:0] d, input int lat);
    exp_t e;
    e.data = d; e.chk_data = 1'b1; e.err = 1'b0; e.at = cyc + lat;
    qb.push_back(e);
  endtask

  // Runs until every raised request has been acked, checking each ack against the scoreboard.
  task automatic run();
    exp_t e;
    int   n;
    n = 0;
    while ((a_req || b_req) && n < 200) begin
      @(negedge clk);
      n++;
      if (a_ack) begin
        if (qa.size() == 0) begin
          chk("a_spurious_ack", 32'(qa.size()), 32'd1);
        end else begin
          e = qa.pop_front();
          chk("a_ack_cycle", 32'(cyc), 32'(e.at));
          chk("a_err", 32'(a_err), 32'(e.err));
          if (e.chk_data) chk("a_rdata", a_rdata, e.data);
        end
        a_req = 1'b0;
      end
      if (b_ack) begin
        if (qb.size() == 0) begin
          chk("b_spurious_ack", 32'(qb.size()), 32'd1);
        end else begin
          e = qb.pop_front();
          chk("b_ack_cycle", 32'(cyc), 32'(e.at));
          chk("b_rdata", {24'd0, b_rdata}, e.data);
        end
        b_req = 1'b0;
      end
    end
    if (a_req || b_req) begin
      chk("ack_timeout", 32'({a_req, b_req}), 32'd0);
      a_req = 1'b0;
      b_req = 1'b0;
    end
  endtask

  task automatic watch_quiet(input int cycles);
    int acks;
    acks = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
    end
    chk("no_ack_after_abort", 32'(acks), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({a_ack, a_err, b_ack, ram_wren, ram_rden}), 32'd0);
    chk({tag, "_a_rdata"}, a_rdata, 32'd0);
    chk({tag, "_b_rdata"}, {24'd0, b_rdata}, 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_data"}, {24'd0, ram_data}, 32'd0);
  endtask

  initial begin
    int w0, r0;

    // Both ports request while in reset; A must win the first grant after release.
    drive_a(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
    b_addr = 16'h0000;
    b_req  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    expect_a(32'h12345678, 1'b1, 1'b0, 9);
    expect_b(32'h000000A5, 13);
    run();

    // Half store, then signed and unsigned half loads.
    go(); w0 = nwr;
    drive_a(1'b1, 2'b01, 1'b0, 16'h0020, 32'h0000BEEF);
    expect_a(32'h0, 1'b0, 1'b0, 3);
    run();
    chk("st_half_pulses", 32'(nwr - w0), 32'd2);
    chk("mem_0020", {24'd0, mem[16'h0020]}, 32'h000000EF);
    chk("mem_0021", {24'd0, mem[16'h0021]}, 32'h000000BE);
    go(); drive_a(1'b0, 2'b01, 1'b0, 16'h0020, 32'h0); expect_a(32'hFFFFBEEF, 1'b1, 1'b0, 5); run();
    go(); drive_a(1'b0, 2'b01, 1'b1, 16'h0020, 32'h0); expect_a(32'h0000BEEF, 1'b1, 1'b0, 5); run();

    // Misaligned and illegal-size accesses: immediate error ack, no RAM traffic, rdata held.
    r0 = nrd; w0 = nwr;
    go(); drive_a(1'b0, 2'b10, 1'b0, 16'h0102, 32'h0); expect_a(32'h0000BEEF, 1'b1, 1'b1, 1); run();
    go(); drive_a(1'b0, 2'b01, 1'b0, 16'h0021, 32'h0); expect_a(32'h0000BEEF, 1'b1, 1'b1, 1); run();
    go(); drive_a(1'b1, 2'b11, 1'b0, 16'h0020, 32'h1); expect_a(32'h0000BEEF, 1'b1, 1'b1, 1); run();
    chk("err_ram_pulses", 32'((nrd - r0) + (nwr - w0)), 32'd0);

    // Byte loads with sign/zero extension.
    go(); drive_a(1'b0, 2'b00, 1'b0, 16'h0020, 32'h0); expect_a(32'hFFFFFFEF, 1'b1, 1'b0, 3); run();
    go(); drive_a(1'b0, 2'b00, 1'b1, 16'h0020, 32'h0); expect_a(32'h000000EF, 1'b1, 1'b0, 3); run();
    go(); drive_a(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0); expect_a(32'h00000012, 1'b1, 1'b0, 3); run();

    // Word store and read-back; a_unsigned is irrelevant for words.
    go(); w0 = nwr;
    drive_a(1'b1, 2'b10, 1'b1, 16'h0040, 32'hCAFEF00D);
    expect_a(32'h0, 1'b0, 1'b0, 5);
    run();
    chk("st_word_pulses", 32'(nwr - w0), 32'd4);
    go(); drive_a(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0); expect_a(32'hCAFEF00D, 1'b1, 1'b0, 9); run();

    // Solo B leaves last-grant at B, so each simultaneous pair is served A then B.
    go(); b_addr = 16'h0011; b_req = 1'b1; expect_b(32'h00000056, 3); run();
    for (int p = 0; p < 2; p++) begin
      go();
      if (p == 0) begin
        drive_a(1'b0, 2'b00, 1'b1, 16'h0012, 32'h0);
        b_addr = 16'h0010;
        expect_a(32'h00000034, 1'b1, 1'b0, 3);
        expect_b(32'h00000078, 7);
      end else begin
        drive_a(1'b0, 2'b00, 1'b0, 16'h0010, 32'h0);
        b_addr = 16'h0013;
        expect_a(32'h00000078, 1'b1, 1'b0, 3);
        expect_b(32'h00000012, 7);
      end
      b_req = 1'b1;
      run();
    end

    // Reset asserted while the third byte of a word store is on the bus.
    go();
    drive_a(1'b1, 2'b10, 1'b0, 16'h0050, 32'h44332211);
    repeat (4) @(negedge clk);
    chk("third_byte_wren", 32'(ram_wren), 32'd1);
    chk("third_byte_addr", 32'(ram_addr), 32'h00000052);
    rst   = 1'b0;
    a_req = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk("mem_0050", {24'd0, mem[16'h0050]}, 32'h00000011);
    chk("mem_0051", {24'd0, mem[16'h0051]}, 32'h00000022);
    chk("mem_0052", {24'd0, mem[16'h0052]}, 32'h00000000);
    @(negedge clk);
    rst = 1'b1;
    watch_quiet(4);
    go(); b_addr = 16'h0000; b_req = 1'b1; expect_b(32'h000000A5, 3); run();

    chk("ram_bus_violations", 32'(nviol), 32'd0);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
